cpu_stack_file: RTL and testbench

- Parametrised data-stack storage for the stack CPU: holds the operand stack, applies committed writeback-stage pop/push updates, and serves two registered read ports (top of stack, and top minus N) to decode.
- Successor to the fixed 35-bit / 11-bit-pointer stack. Adds:
  - configurable width and depth;
  - multi-element pop with an optional push in one commit;
  - same-cycle write bypass;
  - sticky overflow/underflow detection;
  - stack-pointer restore for context switches.

---
 rtl/cpu_stack_file.sv | 140 ++++++++++++++
 tb/tb_cpu_stack_file.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_stack_file.sv
// cpu_stack_file
//   Data-stack storage for the stack CPU. Holds the operand stack, applies
//   committed writeback pop/push updates, and serves two registered read
//   ports (top of stack, and top minus rd_n) to decode.
//
// Ports
//   clk, rst_b       clock, asynchronous active-low reset
//   commit_valid     writeback commit strobe
//   commit_pop       number of entries removed by the commit
//   commit_push      push one entry (commit_data) after the pop
//   commit_data      entry pushed
//   restore_valid    load sp from restore_sp (saturated to DEPTH); drops any
//                    same-cycle commit
//   restore_sp       stack pointer value to load
//   rd_n             depth index for top_n (0 = top)
//   err_clr          clear sticky error flags (a same-cycle error wins)
//   top_0/_valid     entry at sp-1, stack non-empty
//   top_n/_valid     entry at sp-1-rd_n, rd_n < sp
//   sp               current entry count
//   err_overflow     sticky overflow flag
//   err_underflow    sticky underflow flag
module cpu_stack_file #(
    parameter int DATA_W = 35,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_pop,
    input  logic              commit_push,
    input  logic [DATA_W-1:0] commit_data,
    input  logic              restore_valid,
    input  logic [ADDR_W:0]   restore_sp,
    input  logic [ADDR_W-1:0] rd_n,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top_0,
    output logic              top_0_valid,
    output logic [DATA_W-1:0] top_n,
    output logic              top_n_valid,
    output logic [ADDR_W:0]   sp,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   sp_q, sp_d;
    logic [DATA_W-1:0] top_0_q, top_0_d, top_n_q, top_n_d;
    logic              top_0_valid_q, top_0_valid_d;
    logic              top_n_valid_q, top_n_valid_d;
    logic              err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

    // All pointer math is ADDR_W+1 bits so nothing wraps at the top.
    logic [ADDR_W:0]   pop_w, post_pop, post_push;
    logic              do_commit, underflow, overflow, legal, wr_en;
    logic [ADDR_W:0]   rd0_addr, rdn_addr;

    always_comb begin
        pop_w     = {1'b0, commit_pop};
        post_pop  = sp_q - pop_w;
        post_push = post_pop + (ADDR_W+1)'(commit_push);

        // A restore swallows the commit completely, including its errors.
        do_commit = commit_valid && !restore_valid;
        underflow = do_commit && (pop_w > sp_q);
        overflow  = do_commit && !underflow && (post_push > DEPTH_C);
        legal     = do_commit && !underflow && !overflow;
        wr_en     = legal && commit_push;

        if (restore_valid)
            sp_d = (restore_sp > DEPTH_C) ? DEPTH_C : restore_sp;
        else if (legal)
            sp_d = post_push;
        else
            sp_d = sp_q;

        // Set has priority over clear.
        err_ovf_d = (err_ovf_q && !err_clr) || overflow;
        err_udf_d = (err_udf_q && !err_clr) || underflow;

        // Read addresses follow the post-update pointer so decode sees the
        // new stack one cycle later. Addresses are only used when valid.
        rd0_addr      = sp_d - 1'b1;
        rdn_addr      = sp_d - 1'b1 - {1'b0, rd_n};
        top_0_valid_d = (sp_d != '0);
        top_n_valid_d = ({1'b0, rd_n} < sp_d);

        top_0_d = '0;
        if (top_0_valid_d) begin
            if (wr_en && rd0_addr == post_pop)
                top_0_d = commit_data;
            else
                top_0_d = mem[rd0_addr[ADDR_W-1:0]];
        end

        top_n_d = '0;
        if (top_n_valid_d) begin
            if (wr_en && rdn_addr == post_pop)
                top_n_d = commit_data;
            else
                top_n_d = mem[rdn_addr[ADDR_W-1:0]];
        end
    end

    // Storage shares the reset block so a write is suppressed while rst_b is
    // low; the array itself is never cleared.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sp_q          <= '0;
            top_0_q       <= '0;
            top_0_valid_q <= 1'b0;
            top_n_q       <= '0;
            top_n_valid_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_udf_q     <= 1'b0;
        end else begin
            if (wr_en)
                mem[post_pop[ADDR_W-1:0]] <= commit_data;
            sp_q          <= sp_d;
            top_0_q       <= top_0_d;
            top_0_valid_q <= top_0_valid_d;
            top_n_q       <= top_n_d;
            top_n_valid_q <= top_n_valid_d;
            err_ovf_q     <= err_ovf_d;
            err_udf_q     <= err_udf_d;
        end
    end

    assign sp            = sp_q;
    assign top_0         = top_0_q;
    assign top_0_valid   = top_0_valid_q;
    assign top_n         = top_n_q;
    assign top_n_valid   = top_n_valid_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;

endmodule

// File: tb/tb_cpu_stack_file.sv
// Directed bench for cpu_stack_file at DATA_W=35, ADDR_W=4, DEPTH=16.
module tb_cpu_stack_file;
    localparam int DATA_W = 35;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              commit_valid;
    logic [ADDR_W-1:0] commit_pop;
    logic              commit_push;
    logic [DATA_W-1:0] commit_data;
    logic              restore_valid;
    logic [ADDR_W:0]   restore_sp;
    logic [ADDR_W-1:0] rd_n;
    logic              err_clr;
    logic [DATA_W-1:0] top_0, top_n;
    logic              top_0_valid, top_n_valid;
    logic [ADDR_W:0]   sp;
    logic              err_overflow, err_underflow;

    int n_pass = 0;
    int n_total = 0;

    cpu_stack_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_b(rst_b),
        .commit_valid(commit_valid), .commit_pop(commit_pop),
        .commit_push(commit_push), .commit_data(commit_data),
        .restore_valid(restore_valid), .restore_sp(restore_sp),
        .rd_n(rd_n), .err_clr(err_clr),
        .top_0(top_0), .top_0_valid(top_0_valid),
        .top_n(top_n), .top_n_valid(top_n_valid),
        .sp(sp), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_valid = 0; commit_pop = '0; commit_push = 0; commit_data = '0;
        restore_valid = 0; restore_sp = '0; err_clr = 0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        commit_valid = 1; commit_pop = '0; commit_push = 1; commit_data = d;
        tick();
    endtask

    task automatic restore(input logic [ADDR_W:0] v);
        idle(); restore_valid = 1; restore_sp = v;
        tick();
        idle();
    endtask

    initial begin
        rst_b = 1; rd_n = '0; idle();
        #1 rst_b = 0;
        #2;
        chk("rst_sp", 64'(sp), 0);
        chk("rst_top0", 64'(top_0), 0);
        chk("rst_valids", {62'd0, top_0_valid, top_n_valid}, 0);
        chk("rst_errs", {62'd0, err_overflow, err_underflow}, 0);
        #9 rst_b = 1;
        tick();

        // Push 1,2,3
        rd_n = 4'd2;
        push(35'h1); push(35'h2); push(35'h3);
        idle();
        chk("push3_sp", 64'(sp), 3);
        chk("push3_top0", {28'd0, top_0_valid, top_0}, {28'd0, 1'b1, 35'h3});
        chk("push3_topn2", {28'd0, top_n_valid, top_n}, {28'd0, 1'b1, 35'h1});
        rd_n = 4'd3;
        tick();
        chk("rdn3_invalid", {28'd0, top_n_valid, top_n}, 0);

        // pop 2 push 1: write at address 1, seen through bypass
        rd_n = 4'd1;
        commit_valid = 1; commit_pop = 4'd2; commit_push = 1; commit_data = 35'h7FF;
        tick(); idle();
        chk("pp_sp", 64'(sp), 2);
        chk("pp_top0_bypass", 64'(top_0), 64'h7FF);
        chk("pp_topn1", 64'(top_n), 64'h1);

        // Underflow: pop 3 from sp=2
        commit_valid = 1; commit_pop = 4'd3; commit_push = 1; commit_data = 35'hABC;
        tick(); idle();
        chk("udf_sp", 64'(sp), 2);
        chk("udf_nowrite", 64'(top_0), 64'h7FF);
        chk("udf_flag", {62'd0, err_underflow, err_overflow}, 2'b10);
        commit_valid = 1; commit_pop = 4'd3; err_clr = 1;
        tick(); idle();
        chk("udf_set_wins", 64'(err_underflow), 1);
        err_clr = 1;
        tick(); idle();
        chk("udf_cleared", 64'(err_underflow), 0);

        // No-op commit
        commit_valid = 1;
        tick(); idle();
        chk("noop", {61'd0, sp, err_underflow, err_overflow}, {61'd0, 5'd2, 2'b00});

        // Restore: prepare mem[0..5] = 0x10..0x15, then sp=2
        restore(5'd0);
        for (int i = 0; i < 6; i++) push(35'h10 + 35'(i));
        idle();
        restore(5'd2);
        chk("rest2_sp", 64'(sp), 2);
        rd_n = 4'd2;
        restore_valid = 1; restore_sp = 5'd5;
        commit_valid = 1; commit_pop = '0; commit_push = 1; commit_data = 35'hDEAD;
        tick(); idle();
        chk("rest5_sp", 64'(sp), 5);
        chk("rest5_top0", 64'(top_0), 64'h14);
        chk("rest5_nowrite", 64'(top_n), 64'h12);
        chk("rest5_noerr", {62'd0, err_overflow, err_underflow}, 0);
        restore(5'd20);
        chk("rest_sat", 64'(sp), 16);

        // Overflow
        restore(5'd0);
        rd_n = 4'd0;
        for (int i = 0; i < 16; i++) push(35'h100 + 35'(i));
        idle();
        chk("full_sp", 64'(sp), 16);
        chk("full_top0", {28'd0, top_0_valid, top_0}, {28'd0, 1'b1, 35'h10F});
        push(35'h999); idle();
        chk("ovf_sp", 64'(sp), 16);
        chk("ovf_flags", {62'd0, err_overflow, err_underflow}, 2'b10);
        chk("ovf_nowrite", 64'(top_0), 64'h10F);
        commit_valid = 1; commit_pop = 4'd1; commit_push = 1; commit_data = 35'h555;
        tick(); idle();
        chk("full_pp_sp", 64'(sp), 16);
        chk("full_pp_top0", 64'(top_0), 64'h555);
        chk("ovf_sticky", 64'(err_overflow), 1);
        err_clr = 1;
        tick(); idle();
        chk("ovf_cleared", 64'(err_overflow), 0);

        // Empty-stack pop underflows
        restore(5'd0);
        commit_valid = 1; commit_pop = 4'd1;
        tick(); idle();
        chk("empty_pop", {61'd0, sp, err_underflow}, {61'd0, 5'd0, 1'b1});
        push(35'h42); idle();
        chk("empty_push", {28'd0, sp, top_0}, {28'd0, 5'd1, 35'h42});

        // Async reset mid-cycle during a push
        commit_valid = 1; commit_pop = '0; commit_push = 1; commit_data = 35'h77;
        #2 rst_b = 0;
        #1;
        chk("arst_sp", 64'(sp), 0);
        chk("arst_out", {26'd0, top_0_valid, top_n_valid, top_0}, 0);
        chk("arst_errs", {62'd0, err_overflow, err_underflow}, 0);
        @(posedge clk); #3;
        idle();
        rst_b = 1;
        tick();
        chk("post_rst_sp", 64'(sp), 0);
        chk("post_rst_valids", {62'd0, top_0_valid, top_n_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
